// File: rtl/weight_fetch_ctrl.sv
// weight_fetch_ctrl: reads packed weight rows and their outlier descriptors
// from two lock-step SRAMs and streams them to the outlier mux over a
// valid/ready handshake. A 2-entry skid FIFO plus a read-credit rule absorb
// the 1-cycle SRAM latency, so backpressure never drops or repeats a row.
module weight_fetch_ctrl #(
    parameter int AW = 10,
    parameter int NW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [NW-1:0] num_rows,
    output logic          busy,
    output logic          done,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   wmem_rdata,
    input  logic [6:0]    olt_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    weight_0,
    output logic [3:0]    weight_1,
    output logic [3:0]    weight_2,
    output logic [3:0]    weight_3,
    output logic [3:0]    weight_4,
    output logic [3:0]    weight_5,
    output logic [3:0]    weight_6,
    output logic [3:0]    weight_7,
    output logic          sel,
    output logic [5:0]    addr
);

    // One row as stored in the FIFO: {weights[31:0], ol_valid, dst[2:0], src[2:0]}
    localparam int RW = 39;
    localparam logic [AW-1:0] ONE_A = 1;
    localparam logic [NW-1:0] ONE_N = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [NW-1:0] rem_q, rem_d;
    logic          inflight_q;
    logic          zdone_q, zdone_d;
    logic [1:0]    count_q, count_d;
    logic          rd_ptr_q, wr_ptr_q;
    logic [RW-1:0] fifo_q [2];

    logic [RW-1:0] ret_row;
    logic [RW-1:0] head_row;
    logic [RW-1:0] out_row;
    logic [2:0]    occ_after_pop;
    logic          pop;
    logic          pop_stored;
    logic          push;
    logic          credit_ok;
    logic          issue;
    logic          drain_done;

    // Row returning from the SRAMs this cycle (valid only when inflight_q).
    assign ret_row = {wmem_rdata, olt_rdata};

    // The returning row is visible at the head straight away when the FIFO
    // is empty, which gives the 2-cycle start-to-valid latency.
    assign out_valid  = (count_q != 2'd0) || inflight_q;
    assign head_row   = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : ret_row;
    assign pop        = out_valid && out_ready;
    assign pop_stored = pop && (count_q != 2'd0);
    assign push       = inflight_q && !(pop && (count_q == 2'd0));
    assign count_d    = count_q + {1'b0, push} - {1'b0, pop_stored};

    // Credit: stored rows + row in flight - row leaving now + new read <= 2.
    assign occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok     = (occ_after_pop <= 3'd1);

    // Next-state logic: job sequencing, read issue and completion.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rem_d      = rem_q;
        zdone_d    = 1'b0;
        issue      = 1'b0;
        drain_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        ptr_d   = base_addr;
                        rem_d   = num_rows;
                        state_d = RUN;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    ptr_d = ptr_q + ONE_A;
                    rem_d = rem_q - ONE_N;
                    if (rem_q == ONE_N) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((count_q == 2'd0) && !inflight_q) begin
                    drain_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = drain_done || zdone_q;
    assign mem_en   = issue;
    assign mem_addr = issue ? ptr_q : '0;

    // Outputs read as zero weights and no outlier whenever nothing is valid.
    assign out_row  = out_valid ? head_row : '0;
    assign weight_0 = out_row[7  +: 4];
    assign weight_1 = out_row[11 +: 4];
    assign weight_2 = out_row[15 +: 4];
    assign weight_3 = out_row[19 +: 4];
    assign weight_4 = out_row[23 +: 4];
    assign weight_5 = out_row[27 +: 4];
    assign weight_6 = out_row[31 +: 4];
    assign weight_7 = out_row[35 +: 4];
    assign sel      = out_row[6];
    assign addr     = out_row[5:0];

    // Control state: FSM, pointers, counters and FIFO occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            inflight_q <= 1'b0;
            zdone_q    <= 1'b0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rem_q      <= rem_d;
            inflight_q <= issue;
            zdone_q    <= zdone_d;
            count_q    <= count_d;
            if (pop_stored) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
        end
    end

    // FIFO storage: capture the returning row unless it leaves immediately.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= ret_row;
        end
    end

endmodule
